// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: initiator side of the ALU port.
//   S1 is the issue register that drives the combinational ALU; S2 is the
//   result register presented downstream as a writeback/branch record.
//   One op per cycle with wb_ready high; a downstream stall freezes both stages.
// Optional feature macro: ALU_OVF_EXC_EN
//   When defined, add/sub overflow on a writeback op is redirected to the
//   status register RSTATUS_REG (data 1 for add, 3 for sub). RSTATUS_REG is
//   only declared in that build, since the default build never reads it.
module alu_issue_ctrl
`ifdef ALU_OVF_EXC_EN
  #(parameter logic [4:0] RSTATUS_REG = 5'd30)
`endif
  (
  input  logic        clock,
  input  logic        ctrl_reset_n,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_kind,
  input  logic [4:0]  req_opcode,
  input  logic [4:0]  req_shamt,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_rd,
  output logic [31:0] alu_operandA,
  output logic [31:0] alu_operandB,
  output logic [4:0]  alu_opcode,
  output logic [4:0]  alu_shiftamt,
  input  logic [31:0] alu_result,
  input  logic        alu_ne,
  input  logic        alu_lt,
  input  logic        alu_ovf,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_ovf,
  output logic        br_taken
);

  typedef enum logic [1:0] {
    K_ALU   = 2'b00,
    K_BNE   = 2'b01,
    K_BLT   = 2'b10,
    K_FLAGS = 2'b11
  } kind_e;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;

  // S1 (issue) registers
  logic        r_s1_valid;
  kind_e       r_s1_kind;
  logic [4:0]  r_s1_rd;
  logic [31:0] r_s1_a;
  logic [31:0] r_s1_b;
  logic [4:0]  r_s1_opcode;
  logic [4:0]  r_s1_shamt;

  // S2 (result) registers
  logic        r_s2_valid;
  logic        r_wb_we;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        r_wb_ovf;
  logic        r_br_taken;

  logic        w_s2_adv;
  logic        w_s1_move;
  logic        w_accept;
  kind_e       w_req_kind;
  logic        w_req_is_br;
  logic        w_nx_we;
  logic [4:0]  w_nx_rd;
  logic [31:0] w_nx_data;
  logic        w_nx_br;

  assign w_s2_adv    = !r_s2_valid || wb_ready;
  assign w_s1_move   = r_s1_valid && w_s2_adv;
  assign req_ready   = ctrl_reset_n && !flush && (!r_s1_valid || w_s2_adv);
  assign w_accept    = req_valid && req_ready;
  assign w_req_kind  = kind_e'(req_kind);
  assign w_req_is_br = (w_req_kind == K_BNE) || (w_req_kind == K_BLT);

  assign alu_operandA = r_s1_a;
  assign alu_operandB = r_s1_b;
  assign alu_opcode   = r_s1_opcode;
  assign alu_shiftamt = r_s1_shamt;

  assign wb_valid = r_s2_valid;
  assign wb_we    = r_wb_we;
  assign wb_rd    = r_wb_rd;
  assign wb_data  = r_wb_data;
  assign wb_ovf   = r_wb_ovf;
  assign br_taken = r_br_taken;

  // Build the S2 record from the S1 op and the ALU's response this cycle
  always_comb begin
    w_nx_rd   = r_s1_rd;
    w_nx_data = alu_result;
    w_nx_we   = (r_s1_kind == K_ALU) && (r_s1_rd != '0);
    w_nx_br   = 1'b0;
    case (r_s1_kind)
      K_BNE:   w_nx_br = alu_ne;
      K_BLT:   w_nx_br = alu_lt;
      default: w_nx_br = 1'b0;
    endcase
`ifdef ALU_OVF_EXC_EN
    if ((r_s1_kind == K_ALU) && alu_ovf &&
        ((r_s1_opcode == OP_ADD) || (r_s1_opcode == OP_SUB))) begin
      w_nx_rd   = RSTATUS_REG;
      w_nx_data = (r_s1_opcode == OP_ADD) ? 32'd1 : 32'd3;
      w_nx_we   = 1'b1;
    end
`endif
  end

  // S1: load on accept (branches forced to subtract), empty when the op moves on
  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_kind   <= K_ALU;
      r_s1_rd     <= '0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_opcode <= '0;
      r_s1_shamt  <= '0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid  <= 1'b1;
      r_s1_kind   <= w_req_kind;
      r_s1_rd     <= req_rd;
      r_s1_a      <= req_a;
      r_s1_b      <= req_b;
      r_s1_opcode <= w_req_is_br ? OP_SUB : req_opcode;
      r_s1_shamt  <= w_req_is_br ? 5'd0 : req_shamt;
    end else if (w_s1_move) begin
      r_s1_valid <= 1'b0;
    end
  end

  // S2: capture the ALU result when S1 advances; drain on handshake otherwise
  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      r_s2_valid <= 1'b0;
      r_wb_we    <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_wb_ovf   <= 1'b0;
      r_br_taken <= 1'b0;
    end else if (flush) begin
      r_s2_valid <= 1'b0;
      r_wb_we    <= 1'b0;
      r_br_taken <= 1'b0;
    end else if (w_s1_move) begin
      r_s2_valid <= 1'b1;
      r_wb_we    <= w_nx_we;
      r_wb_rd    <= w_nx_rd;
      r_wb_data  <= w_nx_data;
      r_wb_ovf   <= alu_ovf;
      r_br_taken <= w_nx_br;
    end else if (r_s2_valid && wb_ready) begin
      r_s2_valid <= 1'b0;
      r_wb_we    <= 1'b0;
      r_br_taken <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a behavioural ALU answers the DUT's ALU port, a
// queue-based model of accepted-but-undelivered ops predicts the outputs
// every cycle, and directed sequences pin specific values.
module tb_alu_issue_ctrl;

  logic        clock = 1'b0;
  logic        ctrl_reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_kind = '0;
  logic [4:0]  req_opcode = '0;
  logic [4:0]  req_shamt = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [4:0]  req_rd = '0;
  logic [31:0] alu_operandA, alu_operandB;
  logic [4:0]  alu_opcode, alu_shiftamt;
  logic [31:0] alu_result;
  logic        alu_ne, alu_lt, alu_ovf;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_ovf;
  logic        br_taken;

  always #5 clock = ~clock;

  alu_issue_ctrl dut (
    .clock(clock), .ctrl_reset_n(ctrl_reset_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_opcode(req_opcode), .req_shamt(req_shamt), .req_a(req_a),
    .req_b(req_b), .req_rd(req_rd),
    .alu_operandA(alu_operandA), .alu_operandB(alu_operandB),
    .alu_opcode(alu_opcode), .alu_shiftamt(alu_shiftamt),
    .alu_result(alu_result), .alu_ne(alu_ne), .alu_lt(alu_lt), .alu_ovf(alu_ovf),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_ovf(wb_ovf), .br_taken(br_taken)
  );

  typedef struct packed {
    logic [31:0] r;
    logic        ovf;
  } res_t;

  typedef struct {
    logic        vis;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        ovf;
    logic        br;
  } rec_t;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned delivered = 0;
  logic        saw_not_ready = 1'b0;
  rec_t        q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU: 0 add, 1 sub, 2 and, 3 or, 4 sll, 5 sra
  function automatic res_t alu_f(input logic [4:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] sh);
    res_t x;
    x.ovf = 1'b0;
    case (op)
      5'd0: begin x.r = a + b; x.ovf = (a[31] == b[31]) && (x.r[31] != a[31]); end
      5'd1: begin x.r = a - b; x.ovf = (a[31] != b[31]) && (x.r[31] != a[31]); end
      5'd2: x.r = a & b;
      5'd3: x.r = a | b;
      5'd4: x.r = a << sh;
      5'd5: x.r = $signed(a) >>> sh;
      default: x.r = '0;
    endcase
    return x;
  endfunction

  always_comb begin
    res_t x;
    x = alu_f(alu_opcode, alu_operandA, alu_operandB, alu_shiftamt);
    alu_result = x.r;
    alu_ovf    = x.ovf;
    alu_ne     = (alu_operandA != alu_operandB);
    alu_lt     = ($signed(alu_operandA) < $signed(alu_operandB));
  end

  // Expected record straight from the request fields
  function automatic rec_t make_rec(input logic [1:0] kind, input logic [4:0] op,
                                    input logic [4:0] sh, input logic [31:0] a,
                                    input logic [31:0] b, input logic [4:0] rd);
    rec_t e;
    res_t x;
    if (kind == 2'b01 || kind == 2'b10) x = alu_f(5'd1, a, b, 5'd0);
    else x = alu_f(op, a, b, sh);
    e.vis = 1'b0; e.rd = rd; e.data = x.r; e.ovf = x.ovf; e.we = 1'b0; e.br = 1'b0;
    case (kind)
      2'b00: begin
        e.we = (rd != 5'd0);
`ifdef ALU_OVF_EXC_EN
        if (x.ovf && (op == 5'd0 || op == 5'd1)) begin
          e.rd = 5'd30; e.data = (op == 5'd0) ? 32'd1 : 32'd3; e.we = 1'b1;
        end
`endif
      end
      2'b01: e.br = (a != b);
      2'b10: e.br = ($signed(a) < $signed(b));
      default: e.br = 1'b0;
    endcase
    return e;
  endfunction

  // Per-cycle compare against the model, then advance the model to the next edge
  always @(negedge clock) begin
    logic exp_rdy, exp_vld, acc;
    exp_rdy = ctrl_reset_n && !flush && !(q.size() == 2 && !wb_ready);
    exp_vld = (q.size() > 0) && q[0].vis;
    check("req_ready", {31'd0, req_ready}, {31'd0, exp_rdy});
    check("wb_valid",  {31'd0, wb_valid},  {31'd0, exp_vld});
    if (exp_vld && wb_valid === 1'b1) begin
      check("wb_we",    {31'd0, wb_we},    {31'd0, q[0].we});
      check("wb_rd",    {27'd0, wb_rd},    {27'd0, q[0].rd});
      check("wb_data",  wb_data,           q[0].data);
      check("wb_ovf",   {31'd0, wb_ovf},   {31'd0, q[0].ovf});
      check("br_taken", {31'd0, br_taken}, {31'd0, q[0].br});
    end
    if (req_ready === 1'b0 && ctrl_reset_n && !flush) saw_not_ready = 1'b1;
    if (!ctrl_reset_n || flush) begin
      q.delete();
    end else begin
      acc = req_valid && exp_rdy;
      if (exp_vld && wb_ready) begin
        void'(q.pop_front());
        delivered++;
      end
      if (q.size() > 0 && !q[0].vis) q[0].vis = 1'b1;
      if (acc) q.push_back(make_rec(req_kind, req_opcode, req_shamt, req_a, req_b, req_rd));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [1:0] kind, input logic [4:0] op, input logic [4:0] sh,
                      input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    logic acc;
    int unsigned n;
    req_kind = kind; req_opcode = op; req_shamt = sh;
    req_a = a; req_b = b; req_rd = rd; req_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clock);
      acc = req_ready;
      tick();
      n++;
    end
    req_valid = 1'b0;
    check("send_accepted", {31'd0, acc}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned d0;
    // Reset state
    tick(); tick();
    check("rst_wb_valid",  {31'd0, wb_valid},  32'd0);
    check("rst_br_taken",  {31'd0, br_taken},  32'd0);
    check("rst_wb_we",     {31'd0, wb_we},     32'd0);
    check("rst_wb_data",   wb_data,            32'd0);
    check("rst_alu_opA",   alu_operandA,       32'd0);
    check("rst_alu_op",    {27'd0, alu_opcode}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    ctrl_reset_n = 1'b1;
    wb_ready = 1'b1;

    // Add 7+5 -> rd3 one cycle after accept
    send(2'b00, 5'd0, 5'd0, 32'd7, 32'd5, 5'd3);
    check("add_alu_opA", alu_operandA, 32'd7);
    check("add_alu_opB", alu_operandB, 32'd5);
    check("add_alu_op",  {27'd0, alu_opcode}, 32'd0);
    tick();
    check("add_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("add_wb_we",    {31'd0, wb_we},    32'd1);
    check("add_wb_rd",    {27'd0, wb_rd},    32'd3);
    check("add_wb_data",  wb_data,           32'd12);
    check("add_wb_ovf",   {31'd0, wb_ovf},   32'd0);

    // BNE equal then BLT -1<2, back-to-back; opcode/shamt forced
    send(2'b01, 5'd2, 5'd7, 32'd4, 32'd4, 5'd9);
    check("bne_alu_op",    {27'd0, alu_opcode},   32'd1);
    check("bne_alu_shamt", {27'd0, alu_shiftamt}, 32'd0);
    send(2'b10, 5'd3, 5'd0, 32'hFFFF_FFFF, 32'd2, 5'd10);
    check("bne_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("bne_br_taken", {31'd0, br_taken}, 32'd0);
    check("bne_wb_we",    {31'd0, wb_we},    32'd0);
    check("blt_alu_op",   {27'd0, alu_opcode}, 32'd1);
    check("blt_alu_opA",  alu_operandA, 32'hFFFF_FFFF);
    tick();
    check("blt_br_taken", {31'd0, br_taken}, 32'd1);
    check("blt_wb_we",    {31'd0, wb_we},    32'd0);

    // Signed overflow on add
    send(2'b00, 5'd0, 5'd0, 32'h7FFF_FFFF, 32'd1, 5'd5);
    tick();
    check("ovf_wb_ovf", {31'd0, wb_ovf}, 32'd1);
`ifdef ALU_OVF_EXC_EN
    check("ovf_wb_rd",   {27'd0, wb_rd}, 32'd30);
    check("ovf_wb_data", wb_data,        32'd1);
`else
    check("ovf_wb_rd",   {27'd0, wb_rd}, 32'd5);
    check("ovf_wb_data", wb_data,        32'h8000_0000);
`endif
    tick();

    // Four streamed ops with a 3-cycle downstream stall after the first record
    d0 = delivered;
    saw_not_ready = 1'b0;
    fork
      begin
        send(2'b00, 5'd1, 5'd0, 32'd100, 32'd1, 5'd1);
        send(2'b00, 5'd2, 5'd0, 32'h0000_F0F0, 32'h0000_0FF0, 5'd2);
        send(2'b00, 5'd4, 5'd4, 32'd3, 32'd0, 5'd4);
        send(2'b11, 5'd0, 5'd0, 32'd10, 32'd20, 5'd6);
      end
      begin
        int unsigned n;
        n = 0;
        while (wb_valid !== 1'b1 && n < 20) begin tick(); n++; end
        wb_ready = 1'b0;
        tick(); tick(); tick();
        wb_ready = 1'b1;
      end
    join
    repeat (4) tick();
    check("stream_delivered", delivered - d0, 32'd4);
    check("stream_backpressure", {31'd0, saw_not_ready}, 32'd1);

    // Flush with both stages full and downstream stalled
    wb_ready = 1'b0;
    send(2'b00, 5'd0, 5'd0, 32'h111, 32'h222, 5'd11);
    send(2'b00, 5'd3, 5'd0, 32'h0F0, 32'h00F, 5'd12);
    check("pre_flush_wb_valid", {31'd0, wb_valid}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_wb_valid", {31'd0, wb_valid}, 32'd0);
    d0 = delivered;
    wb_ready = 1'b1;
    repeat (4) tick();
    check("flush_no_record", delivered - d0, 32'd0);

    // Reset with ops in flight, then a clean op
    wb_ready = 1'b0;
    send(2'b10, 5'd0, 5'd0, 32'd1, 32'd5, 5'd13);
    send(2'b00, 5'd0, 5'd0, 32'd9, 32'd9, 5'd14);
    check("pre_rst_br_taken", {31'd0, br_taken}, 32'd1);
    ctrl_reset_n = 1'b0;
    tick();
    check("rst2_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst2_br_taken", {31'd0, br_taken}, 32'd0);
    check("rst2_alu_opA",  alu_operandA,      32'd0);
    ctrl_reset_n = 1'b1;
    wb_ready = 1'b1;
    send(2'b00, 5'd0, 5'd0, 32'd2, 32'd3, 5'd7);
    tick();
    check("post_rst_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("post_rst_wb_rd",    {27'd0, wb_rd},    32'd7);
    check("post_rst_wb_data",  wb_data,           32'd5);
    check("post_rst_wb_we",    {31'd0, wb_we},    32'd1);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
